// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: datapath width, canonical NOP and
// the fetch-to-decode entry bundle.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch-to-decode decoupling queue with single-cycle flush.
// Ready/valid derive only from registered occupancy.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = riscv_pkg::XLEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [XLEN-1:0]              in_pc_i,
    input  logic [XLEN-1:0]              in_instruction_i,
    input  logic                         flush_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [XLEN-1:0]              out_pc_o,
    output logic [XLEN-1:0]              out_instruction_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    import riscv_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t mem_q [DEPTH];

    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic push;
    logic pop;
    fetch_entry_t head;

    assign in_ready_o  = (cnt_q != CNT_W'(DEPTH));
    assign out_valid_o = (cnt_q != '0);
    assign count_o     = cnt_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_W'(1);
            if (pop)  rd_d = rd_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; empty slots are masked at the output.
    always_ff @(posedge clk) begin
        if (push && !flush_i && !rst) begin
            mem_q[wr_q] <= '{pc: in_pc_i, instruction: in_instruction_i};
        end
    end

    always_comb begin
        head              = mem_q[rd_q];
        out_pc_o          = '0;
        out_instruction_o = NOP_INSTR;
        if (out_valid_o) begin
            out_pc_o          = head.pc;
            out_instruction_o = head.instruction;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table plus
// randomized traffic against a queue-based reference model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h00000013;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [XLEN-1:0]  in_pc_i;
    logic [XLEN-1:0]  in_instruction_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  out_pc_o;
    logic [XLEN-1:0]  out_instruction_o;
    logic [CNT_W-1:0] count_o;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .in_pc_i           (in_pc_i),
        .in_instruction_i  (in_instruction_i),
        .flush_i           (flush_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_pc_o          (out_pc_o),
        .out_instruction_o (out_instruction_o),
        .count_o           (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        fl;
        logic        rd;
        int          exp_cnt;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] mq[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] epc;
        logic [31:0] ein;
        epc = 32'h0;
        ein = NOP;
        if (mq.size() != 0) begin
            epc = mq[0][63:32];
            ein = mq[0][31:0];
        end
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("out_valid", 32'(out_valid_o), 32'(mq.size() != 0));
        chk("in_ready", 32'(in_ready_o), 32'(mq.size() < DEPTH));
        chk("out_pc", out_pc_o, epc);
        chk("out_instr", out_instruction_o, ein);
        chk("occ_bound", 32'(count_o <= DEPTH), 32'd1);
    endtask

    task automatic cyc(input logic r, input logic v,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic rd);
        bit mr;
        bit mv;
        rst              = r;
        in_valid_i       = v;
        in_pc_i          = pc;
        in_instruction_i = ins;
        flush_i          = fl;
        out_ready_i      = rd;
        @(posedge clk);
        mr = mq.size() < DEPTH;
        mv = mq.size() != 0;
        if (r || fl) begin
            mq.delete();
        end else begin
            if (mv && rd) void'(mq.pop_front());
            if (v && mr) mq.push_back({pc, ins});
        end
        #1;
        check_model();
    endtask

    function automatic vec_t mk(logic r, logic v, logic [31:0] pc,
                                logic [31:0] ins, logic fl, logic rd,
                                int c, logic ev, logic [31:0] ep);
        vec_t t;
        t.r = r; t.v = v; t.pc = pc; t.ins = ins;
        t.fl = fl; t.rd = rd;
        t.exp_cnt = c; t.exp_valid = ev; t.exp_pc = ep;
        return t;
    endfunction

    initial begin
        rst              = 1'b1;
        in_valid_i       = 1'b0;
        in_pc_i          = '0;
        in_instruction_i = '0;
        flush_i          = 1'b0;
        out_ready_i      = 1'b0;

        // reset and idle
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // fill, then rejected fifth push
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 32'(4*k), 32'hA0 + 32'(k),
                              0, 0, k + 1, 1, 0));
        vecs.push_back(mk(0, 1, 32'h10, 32'hA4, 0, 0, 4, 1, 0));
        // drain in order
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 1, 32'h4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 1, 32'h8));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 32'hC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        // streaming through pointer wrap
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(0, 1, 32'(4*k), 32'hB0 + 32'(k),
                              0, 1, 1, 1, 32'(4*k)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        // flush with simultaneous push and pop
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 1, 32'h40 + 32'(4*k), 32'hC0,
                              0, 0, k + 1, 1, 32'h40));
        vecs.push_back(mk(0, 1, 32'h100, 32'hDD, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        // reset mid-operation with push pending
        vecs.push_back(mk(0, 1, 32'h200, 32'hE0, 0, 0, 1, 1, 32'h200));
        vecs.push_back(mk(0, 1, 32'h204, 32'hE1, 0, 0, 2, 1, 32'h200));
        vecs.push_back(mk(1, 1, 32'h208, 32'hE2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // full with pop: no push that cycle, ready back next cycle
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 32'h300 + 32'(4*k), 32'hF0,
                              0, 0, k + 1, 1, 32'h300));
        vecs.push_back(mk(0, 1, 32'h310, 32'hF4, 0, 1, 3, 1, 32'h304));
        vecs.push_back(mk(0, 1, 32'h314, 32'hF5, 0, 0, 4, 1, 32'h304));

        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].v, vecs[i].pc, vecs[i].ins,
                vecs[i].fl, vecs[i].rd);
            chk($sformatf("vec%0d_count", i), 32'(count_o),
                32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid_o),
                32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_pc", i), out_pc_o, vecs[i].exp_pc);
        end

        // randomized traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 3) != 0,
                $urandom, $urandom,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
